// File: rtl/lc3_decode_issue.sv
// LC-3 decode/operand-fetch stage: register decode, pending-write scoreboard
// for RAW hazards, and a single ID/EX pipeline register with valid/ready.
module lc3_decode_issue #(
    parameter int CNT_W = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    input  logic [15:0] if_ir,
    input  logic [15:0] if_pc,
    output logic        id_ready,
    output logic [2:0]  rf_sr1,
    output logic [2:0]  rf_sr2,
    input  logic [15:0] rf_sr1_data,
    input  logic [15:0] rf_sr2_data,
    output logic        ex_valid,
    input  logic        ex_ready,
    output logic [15:0] ex_ir,
    output logic [15:0] ex_pc,
    output logic [15:0] ex_sr1_val,
    output logic [15:0] ex_sr2_val,
    output logic [2:0]  ex_dr,
    output logic        ex_wr_en,
    input  logic        wb_ld,
    input  logic [2:0]  wb_dr,
    input  logic        flush
);

    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [3:0]       op;
    logic             use_sr1;
    logic             use_sr2;
    logic             wr_en;
    logic [2:0]       dr;
    logic             hazard;
    logic             issue;
    logic             flush_dec;
    logic [CNT_W-1:0] cnt     [8];
    logic [CNT_W-1:0] cnt_nxt [8];

    // Register-field decode; addresses go to the register file regardless of if_valid.
    always_comb begin
        op      = if_ir[15:12];
        rf_sr1  = ((op == OP_ST) || (op == OP_STI)) ? if_ir[11:9] : if_ir[8:6];
        rf_sr2  = (op == OP_STR) ? if_ir[11:9] : if_ir[2:0];
        use_sr1 = 1'b0;
        use_sr2 = 1'b0;
        wr_en   = 1'b0;
        dr      = 3'd0;
        case (op)
            OP_ADD, OP_AND: begin
                use_sr1 = 1'b1;
                use_sr2 = !if_ir[5];
                wr_en   = 1'b1;
                dr      = if_ir[11:9];
            end
            OP_NOT, OP_LDR: begin
                use_sr1 = 1'b1;
                wr_en   = 1'b1;
                dr      = if_ir[11:9];
            end
            OP_LD, OP_LDI, OP_LEA: begin
                wr_en = 1'b1;
                dr    = if_ir[11:9];
            end
            OP_ST, OP_STI, OP_JMP: begin
                use_sr1 = 1'b1;
            end
            OP_STR: begin
                use_sr1 = 1'b1;
                use_sr2 = 1'b1;
            end
            OP_JSR: begin
                use_sr1 = !if_ir[11];
                wr_en   = 1'b1;
                dr      = 3'd7;
            end
            OP_TRAP: begin
                wr_en = 1'b1;
                dr    = 3'd7;
            end
            default: ;
        endcase
    end

    // A full counter on the destination also stalls, so counters can never overflow.
    assign hazard = (use_sr1 && (cnt[rf_sr1] != CNT_ZERO))
                 || (use_sr2 && (cnt[rf_sr2] != CNT_ZERO))
                 || (wr_en   && (cnt[dr] == CNT_MAX));

    assign id_ready  = (!ex_valid || ex_ready) && !hazard && !flush;
    assign issue     = if_valid && id_ready;
    assign flush_dec = flush && ex_valid && ex_wr_en;

    // Net per-register update: up to one increment (issue) against up to two
    // decrements (writeback and flushed entry), saturating at zero.
    always_comb begin
        logic       inc;
        logic [1:0] n_dec;
        logic [1:0] k;
        inc   = 1'b0;
        n_dec = 2'd0;
        k     = 2'd0;
        for (int i = 0; i < 8; i++) begin
            inc   = issue && wr_en && (dr == 3'(i));
            n_dec = {1'b0, (wb_ld && (wb_dr == 3'(i)))}
                  + {1'b0, (flush_dec && (ex_dr == 3'(i)))};
            k     = inc ? ((n_dec == 2'd0) ? 2'd0 : n_dec - 2'd1) : n_dec;
            if (inc && (n_dec == 2'd0)) begin
                cnt_nxt[i] = (cnt[i] == CNT_MAX) ? cnt[i] : cnt[i] + CNT_ONE;
            end else if (k == 2'd0) begin
                cnt_nxt[i] = cnt[i];
            end else if (k == 2'd1) begin
                cnt_nxt[i] = (cnt[i] == CNT_ZERO) ? CNT_ZERO : cnt[i] - CNT_ONE;
            end else begin
                cnt_nxt[i] = (cnt[i] <= CNT_ONE) ? CNT_ZERO : cnt[i] - CNT_ONE - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                cnt[i] <= CNT_ZERO;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid   <= 1'b0;
            ex_ir      <= 16'h0000;
            ex_pc      <= 16'h0000;
            ex_sr1_val <= 16'h0000;
            ex_sr2_val <= 16'h0000;
            ex_dr      <= 3'd0;
            ex_wr_en   <= 1'b0;
        end else if (issue) begin
            ex_valid   <= 1'b1;
            ex_ir      <= if_ir;
            ex_pc      <= if_pc;
            ex_sr1_val <= rf_sr1_data;
            ex_sr2_val <= rf_sr2_data;
            ex_dr      <= dr;
            ex_wr_en   <= wr_en;
        end else if (flush || ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

endmodule

// File: doc/lc3_decode_issue.md
Name: lc3_decode_issue

Overview:
- Decode/operand-fetch stage of the pipelined LC-3. Sits between fetch and execute, and drives the register file's read addresses.
- Takes IR/PC from fetch and decodes source and destination registers. Reads operands from the register file combinationally.
- Blocks read-after-write hazards with a per-register pending-write scoreboard. Holds one ID/EX pipeline register with valid/ready handshakes on both sides.

Parameters:
- CNT_W, 2, width of each per-register pending-write counter (max in-flight writes per register = 2^CNT_W-1)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- if_valid  in  1  fetch presents an instruction
- if_ir  in  16  instruction word
- if_pc  in  16  incremented PC of the instruction
- id_ready  out  1  stage accepts if_ir this cycle
- rf_sr1  out  3  register file SR1 address
- rf_sr2  out  3  register file SR2 address
- rf_sr1_data  in  16  register file SR1OUT
- rf_sr2_data  in  16  register file SR2OUT
- ex_valid  out  1  ID/EX entry valid
- ex_ready  in  1  execute consumes entry this cycle
- ex_ir  out  16  latched instruction
- ex_pc  out  16  latched PC
- ex_sr1_val  out  16  latched SR1 operand
- ex_sr2_val  out  16  latched SR2 operand
- ex_dr  out  3  destination register
- ex_wr_en  out  1  instruction writes ex_dr
- wb_ld  in  1  writeback retires a register write (same strobe as register file LD)
- wb_dr  in  3  register written by writeback
- flush  in  1  branch redirect; discard ID/EX entry

Behaviour:
- Opcode op = if_ir[15:12].
- rf_sr1 decode:
  - IR[11:9] for ST(0011) and STI(1011).
  - Otherwise IR[8:6].
- rf_sr2 decode:
  - IR[11:9] for STR(0111).
  - Otherwise IR[2:0].
- use_sr1 is set for: ADD, AND, NOT, LDR, STR, ST, STI, JMP(1100), and JSR(0100) with IR[11]=0.
- use_sr2 is set for: ADD/AND with IR[5]=0, and STR.
- Write decode:
  - wr_en=1 with dr=IR[11:9] for ADD, AND, NOT, LD, LDI, LDR, LEA.
  - wr_en=1 with dr=7 for JSR/JSRR and TRAP.
  - Otherwise wr_en=0, dr=0.
- Scoreboard: 8 counters of CNT_W bits, all 0 at reset.
  - Increment cnt[dr] on issue with wr_en.
  - Decrement cnt[wb_dr] on wb_ld.
  - Both events on the same register in one cycle leave it unchanged.
  - Never wraps: decrement at 0 is ignored.
- hazard = (use_sr1 & cnt[rf_sr1]!=0) | (use_sr2 & cnt[rf_sr2]!=0) | (wr_en & cnt[dr]==max).
- id_ready = (!ex_valid | ex_ready) & !hazard & !flush. Combinational.
- issue = if_valid & id_ready. At the clock edge, issue loads all ex_* fields from the current-cycle decode and register file data, and sets ex_valid.
- Otherwise, ex_ready & ex_valid clears ex_valid. Entry held stable while ex_valid & !ex_ready.
- Writeback timing: a write retired at edge N is visible to an issue at edge N+1. There is no forwarding, so a same-cycle wb_ld does not clear a hazard.
- flush:
  - ex_valid<=0 at the next edge and no issue that cycle.
  - If the discarded entry had ex_wr_en, cnt[ex_dr] is decremented, combined with any wb_ld on the same register per the rule above.
- Reset (async, rst_n=0): ex_valid=0, ex_ir/ex_pc/ex_sr1_val/ex_sr2_val=0, ex_dr=0, ex_wr_en=0, all counters 0. Takes effect mid-transfer with no partial state retained.
- Latency: 1 cycle from if_ir to ex_*. Throughput is 1 instruction/cycle absent hazards.

Test Plan:
- Reset then ADD R1,R2,R3 (0x1283) with R2=5, R3=7 and ex_ready=1 → next cycle ex_valid=1, ex_sr1_val=5, ex_sr2_val=7, ex_dr=1, ex_wr_en=1, cnt[1]=1.
- ADD R1,R2,R3, then AND R4,R1,#0 (0x5860) → id_ready=0 until wb_ld/wb_dr=1 retires; AND issues the cycle after retirement with the new R1.
- ex_ready=0 with entry held → ex_* stable over 3 cycles, id_ready=0; raising ex_ready drains the entry and the next instruction issues the same edge.
- STR R5,R6,#2 (0x7B82) → rf_sr1=6, rf_sr2=5, ex_wr_en=0, scoreboard unchanged.
- Issue JSRR R2 (0x4080), then assert flush with ex_ready=0 → ex_valid=0 next edge and cnt[7] returns to 0. Simultaneous flush with wb_ld on R7 from an older write → cnt[7] decremented twice, ending 0 from 2.
- Drop rst_n mid-stall with cnt[1]=2 → all outputs 0 immediately and counters cleared; ADD using R1 issues right after release.
